winner_decoder: RTL

Consumer end of the winner-selection path: accepts the encoded winner index and winning value produced by the comparator tree and turns them into per-neuron actions. A valid index (1..p_n) becomes a one-hot learn pulse to the selected neuron. Index 0 ("no neuron fired") or any out-of-range code becomes a global miss pulse, which drives threshold decay. The block then enforces a refractory window before accepting the next decision. It sits between the comparator tree and the neuron array's learn/threshold-update inputs.

---
 rtl/winner_decoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/winner_decoder.sv
// Purpose: turns an encoded winner index into a one-hot learn pulse or a global miss pulse, then holds off for a refractory window.
// Latency: 1 cycle from accept edge to first learn/miss pulse cycle; pulse lasts p_pulse cycles, followed by p_refr refractory cycles.
// Backpressure: o_ready is low while a pulse or refractory window is in progress; i_valid seen while not ready is dropped, never queued.
//
// Ports:
//   i_clk       clock, all logic on the rising edge
//   i_rst_n     synchronous active-low reset
//   i_valid     decision present on i_index / i_value
//   i_index     encoded winner: 0 = no winner, k = neuron k-1, > p_n = invalid code
//   i_value     winning value from the comparator tree
//   o_ready     decision accepted this cycle if i_valid is high
//   o_learn     one-hot learn pulse, bit k = neuron k
//   o_miss      no-winner pulse (drives threshold decay)
//   o_value     value captured at the last accept
//   o_busy      pulse or refractory window in progress
//   o_err       sticky flag, set on an out-of-range index
//   o_miss_cnt  saturating count of accepted misses
module winner_decoder #(
    parameter int p_width = 21,
    parameter int p_n     = 4,
    parameter int p_iw    = 3,
    parameter int p_pulse = 2,
    parameter int p_refr  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [p_iw-1:0]    i_index,
    input  logic [p_width-1:0] i_value,
    output logic               o_ready,
    output logic [p_n-1:0]     o_learn,
    output logic               o_miss,
    output logic [p_width-1:0] o_value,
    output logic               o_busy,
    output logic               o_err,
    output logic [15:0]        o_miss_cnt
);

    // One counter serves both the pulse and refractory phases; it is
    // cleared on every phase change, so it only needs to span the longer one.
    localparam int CMAX = (p_pulse > p_refr) ? p_pulse : p_refr;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    // Highest index code that maps onto a real neuron.
    localparam logic [p_iw-1:0] IDX_MAX = p_iw'(p_n);

    localparam logic [15:0] MISS_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_REFR
    } state_t;

    // Captured decision: index drives the decode, value goes straight out.
    typedef struct packed {
        logic [p_iw-1:0]    idx;
        logic [p_width-1:0] value;
    } dec_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    dec_t           dec_q, dec_d;
    logic [p_n-1:0] learn_q, learn_d;
    logic           miss_q, miss_d;
    logic           err_q, err_d;
    logic [15:0]    miss_cnt_q, miss_cnt_d;

    logic accept;
    logic in_oor;
    logic in_miss;
    logic pulse_last;
    logic refr_last;

    assign o_ready = (state_q == ST_IDLE) && i_rst_n;
    assign accept  = i_valid && o_ready;

    // Classification of the incoming code; only meaningful on accept.
    assign in_oor  = (i_index > IDX_MAX);
    assign in_miss = (i_index == '0) || in_oor;

    // Counter runs 0 .. len-1 inside each phase, so the phase occupies
    // exactly len cycles.
    assign pulse_last = (cnt_q == CW'(p_pulse - 1));
    assign refr_last  = (cnt_q == CW'(p_refr - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dec_d      = dec_q;
        err_d      = err_q;
        miss_cnt_d = miss_cnt_q;
        learn_d    = '0;
        miss_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_PULSE;
                    cnt_d       = '0;
                    dec_d.idx   = i_index;
                    dec_d.value = i_value;
                    err_d       = err_q | in_oor;
                    if (in_miss && (miss_cnt_q != MISS_CNT_MAX)) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                end
            end

            ST_PULSE: begin
                if (pulse_last) begin
                    cnt_d   = '0;
                    // With no refractory window the block is ready again
                    // straight after the pulse.
                    state_d = (p_refr == 0) ? ST_IDLE : ST_REFR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_REFR: begin
                if (refr_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pulse outputs are registered from the next state, so they rise in
        // the first PULSE cycle and fall as soon as PULSE is left. Decoding
        // dec_d (not dec_q) lets the new decision show up without an extra
        // cycle. An out-of-range code matches no learn bit and goes to miss.
        if (state_d == ST_PULSE) begin
            for (int k = 0; k < p_n; k++) begin
                learn_d[k] = (dec_d.idx == p_iw'(k + 1));
            end
            miss_d = (dec_d.idx == '0) || (dec_d.idx > IDX_MAX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dec_q      <= '0;
            learn_q    <= '0;
            miss_q     <= 1'b0;
            err_q      <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dec_q      <= dec_d;
            learn_q    <= learn_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign o_learn    = learn_q;
    assign o_miss     = miss_q;
    assign o_value    = dec_q.value;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_err      = err_q;
    assign o_miss_cnt = miss_cnt_q;

endmodule
